// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: instruction-memory port, redirect/halt
// control from the PC/branch logic, and the decode-side valid/ready port.
// master = fetch controller, slave = surrounding system (memory, branch, decode).
interface fetch_if;
  logic [15:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;

  modport master (
    output imem_pc,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output halted,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  halted,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues word addresses to a registered
// instruction memory, buffers returned words in a small FIFO and hands
// them to decode over valid/ready. Redirects toggle an epoch bit so a word
// already in flight from the old path is dropped on return.
// Optional macro FETCH_CTRL_PERF_EN adds perf_fetched / perf_stall counters.
//
// state | meaning
// BOOT  | one idle cycle after reset, no fetch issued
// RUN   | issuing fetches whenever the FIFO has credit
// HALT  | no new fetches; in-flight word captured, FIFO still drains
module fetch_controller #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic          epoch_q, epoch_d;
  logic          inflight_q, inflight_d;
  logic [15:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_epoch_q, inflight_epoch_d;

  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic [15:0]   pc_mem_q    [FIFO_DEPTH];

  logic          pop, push, issue;
  logic [CW:0]   credit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  assign pop    = (count_q != '0) && bus.out_ready;
  assign push   = inflight_q && (inflight_epoch_q == epoch_q);
  // Words already owned (buffered + in flight) after this cycle's pop.
  assign credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

  assign bus.imem_pc   = fetch_pc_q;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign bus.out_pc    = pc_mem_q[rd_ptr_q];

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_BOOT;
      fetch_pc_q       <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
    end
  end

  // Next state, fetch issue and redirect handling.
  always_comb begin
    state_d          = state_q;
    issue            = 1'b0;
    fetch_pc_d       = fetch_pc_q;
    epoch_d          = epoch_q;
    inflight_d       = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!bus.redirect_valid && bus.halt_req) state_d = ST_HALT;
      ST_HALT: if (bus.redirect_valid) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (state_q == ST_RUN && !bus.redirect_valid && credit < DEPTH_W)
      issue = 1'b1;

    if (issue) begin
      fetch_pc_d       = fetch_pc_q + 16'd4;
      inflight_d       = 1'b1;
      inflight_pc_d    = fetch_pc_q;
      inflight_epoch_d = epoch_q;
    end

    // Redirect wins: new path, new epoch, nothing in flight.
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & 16'hFFFC;
      epoch_d    = ~epoch_q;
    end
  end

  // Output FIFO: capture returning words, pop on handshake, flush on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      if (push) begin
        instr_mem_q[wr_ptr_q] <= bus.imem_instr;
        pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      end
      if (bus.redirect_valid) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
    end
  end

  // The issue credit rule guarantees a returning word always has a free slot.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> ({1'b0, count_q} < DEPTH_W));

`ifdef FETCH_CTRL_PERF_EN
  // Delivered-word and decode-stall counters; free-running, survive redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (bus.out_valid && !bus.out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios followed by random
// ready/redirect/halt traffic. The reference tracks, per accepted word, the
// byte PC decode should see next (sequential +4, restarted on redirect),
// the halted flag, head stability under back-pressure and the halt drain bound.
module tb_fetch_controller;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus();

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  fetch_controller #(.RESET_PC(16'h0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  // Registered-read instruction memory: word i holds {C0DE, i}.
  always @(posedge clk) bus.imem_instr <= {16'hC0DE, 2'b00, bus.imem_pc[15:2]};

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] exp_pc;
  bit          halted_exp, booting, prev_stall;
  logic [15:0] prev_pc;
  logic [31:0] prev_instr;
  int          hs_cnt, after_halt, idle, max_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: called at a negedge, checks settled outputs, drives inputs,
  // advances the reference by what the next posedge will do.
  task automatic step(input bit rdy, input bit rv, input logic [15:0] rp, input bit hr);
    bit hs;
    chk("halted", bus.halted, halted_exp);
    if (prev_stall) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_pc", bus.out_pc, prev_pc);
      chk("hold_instr", bus.out_instr, prev_instr);
    end
    bus.out_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
    bus.halt_req = hr;
    hs = bus.out_valid && rdy;
    if (hs) begin
      chk("out_pc", bus.out_pc, exp_pc);
      chk("out_instr", bus.out_instr, {16'hC0DE, 2'b00, exp_pc[15:2]});
      exp_pc = exp_pc + 16'd4;
      hs_cnt++;
      if (halted_exp) after_halt++;
    end
    if (!halted_exp && !booting && rdy && !rv) begin
      idle = hs ? 0 : idle + 1;
    end else begin
      idle = 0;
    end
    if (idle > max_idle) max_idle = idle;
    prev_stall = bus.out_valid && !rdy && !rv;
    prev_pc = bus.out_pc;
    prev_instr = bus.out_instr;
    if (rv) begin
      exp_pc = rp & 16'hFFFC;
      halted_exp = 1'b0;
    end else if (hr && !booting) begin
      if (!halted_exp) after_halt = 0;
      halted_exp = 1'b1;
    end
    booting = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_req = 1'b0;
    exp_pc = 16'h0000;
    halted_exp = 1'b0;
    booting = 1'b1;
    prev_stall = 1'b0;
    idle = 0;
    @(negedge clk);
    chk("rst_imem_pc", bus.imem_pc, 16'h0000);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_pc", bus.out_pc, 16'h0);
    chk("rst_halted", bus.halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    logic [15:0] pc_hold;
    hs_cnt = 0; after_halt = 0; max_idle = 0;

    // 1: sequential fetch after reset, one word per cycle.
    do_reset();
    step(1, 0, 0, 0); chk("t1_valid_k1", bus.out_valid, 0);
    step(1, 0, 0, 0); chk("t1_valid_k2", bus.out_valid, 0);
    step(1, 0, 0, 0); chk("t1_valid_k3", bus.out_valid, 1);
    chk("t1_first_pc", bus.out_pc, 16'h0000);
    h0 = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      chk("t1_stream_valid", bus.out_valid, 1);
      step(1, 0, 0, 0);
    end
    chk("t1_hs_count", hs_cnt - h0, 8);

    // 2: back-pressure holds the head and stops issue at FIFO depth.
    do_reset();
    for (int i = 0; i < 10 && !bus.out_valid; i++) step(0, 0, 0, 0);
    chk("t2_first_valid", bus.out_valid, 1);
    chk("t2_head_pc", bus.out_pc, 16'h0000);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("t2_issue_limit", bus.imem_pc, 16'(4 * DEPTH));
    h0 = hs_cnt;
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    chk("t2_release_hs", hs_cnt - h0, 6);

    // 3: redirect with words in flight; stale words must not appear.
    step(1, 0, 0, 0);
    step(1, 1, 16'h0043, 0); chk("t3_flush_k1", bus.out_valid, 0);
    step(1, 0, 0, 0);        chk("t3_flush_k2", bus.out_valid, 0);
    step(1, 0, 0, 0);        chk("t3_valid_k3", bus.out_valid, 1);
    chk("t3_target_pc", bus.out_pc, 16'h0040);
    chk("t3_target_instr", bus.out_instr, 32'hC0DE0010);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

    // 4: halt drains at most DEPTH words, then redirect resumes.
    step(1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    chk("t4_halted", bus.halted, 1);
    chk("t4_drained", bus.out_valid, 0);
    chk("t4_drain_bound", (after_halt <= DEPTH), 1);
    pc_hold = bus.imem_pc;
    step(1, 0, 0, 0);
    chk("t4_no_issue", bus.imem_pc, pc_hold);
    step(1, 1, 16'h0100, 0); chk("t4_unhalt", bus.halted, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);        chk("t4_resume_valid", bus.out_valid, 1);
    chk("t4_resume_pc", bus.out_pc, 16'h0100);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

    // 5: wrap of the 16-bit PC.
    step(1, 1, 16'hFFF8, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t5_first_pc", bus.out_pc, 16'hFFF8);
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("t5_hs_count", hs_cnt - h0, 4);

    // 6: asynchronous reset with a full FIFO.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("t6_full_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_valid", bus.out_valid, 0);
    chk("t6_async_pc", bus.imem_pc, 16'h0000);
    @(negedge clk);
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t6_restart_valid", bus.out_valid, 1);
    chk("t6_restart_pc", bus.out_pc, 16'h0000);

    // Random traffic.
    max_idle = 0;
    for (int i = 0; i < 600; i++) begin
      bit r, v, h;
      logic [15:0] p;
      r = ($urandom_range(0, 9) < 7);
      v = ($urandom_range(0, 19) == 0);
      h = ($urandom_range(0, 24) == 0);
      p = 16'($urandom);
      step(r, v, p, h);
    end
    chk("rand_liveness", (max_idle <= 6), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
